// File: rtl/aes128_enc_iter.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// The state and the key are both held row-major: byte(r,c) sits at bits [127-32r-8c -: 8].
module aes128_enc_iter #(
   parameter int NUM_ROUNDS = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_text,
   input  logic [127:0] in_key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_text,
   output logic         busy
);

   if (NUM_ROUNDS != 10) begin : g_bad_rounds
      $error("aes128_enc_iter: only NUM_ROUNDS = 10 (AES-128) is supported");
   end

   localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

   fsm_t         fsm;
   fsm_t         fsm_next;
   logic [127:0] state;
   logic [127:0] rk;
   logic [3:0]   round;
   logic [127:0] rk_next;
   logic [127:0] state_next;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX_TABLE[11'd2047 - {x, 3'b000} -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] v;
      v = 8'h00;
      case (r)
         4'd1:    v = 8'h01;
         4'd2:    v = 8'h02;
         4'd3:    v = 8'h04;
         4'd4:    v = 8'h08;
         4'd5:    v = 8'h10;
         4'd6:    v = 8'h20;
         4'd7:    v = 8'h40;
         4'd8:    v = 8'h80;
         4'd9:    v = 8'h1b;
         4'd10:   v = 8'h36;
         default: v = 8'h00;
      endcase
      return v;
   endfunction

   // Key word w[c] is column c of the row-major key, row-0 byte in the MSBs.
   function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0]  w [4];
      logic [31:0]  t;
      logic [127:0] o;
      for (int c = 0; c < 4; c++)
         w[c] = {k[127-8*c -: 8], k[95-8*c -: 8], k[63-8*c -: 8], k[31-8*c -: 8]};
      t = {sbox(w[3][23:16]) ^ rc, sbox(w[3][15:8]), sbox(w[3][7:0]), sbox(w[3][31:24])};
      w[0] = w[0] ^ t;
      w[1] = w[1] ^ w[0];
      w[2] = w[2] ^ w[1];
      w[3] = w[3] ^ w[2];
      o = '0;
      for (int c = 0; c < 4; c++) begin
         o[127-8*c -: 8] = w[c][31:24];
         o[95-8*c -: 8]  = w[c][23:16];
         o[63-8*c -: 8]  = w[c][15:8];
         o[31-8*c -: 8]  = w[c][7:0];
      end
      return o;
   endfunction

   // SubBytes and ShiftRows are fused by reading the source byte from column (c+r)%4.
   function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [7:0]   b [4][4];
      logic [7:0]   m [4][4];
      logic [127:0] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            b[r][c] = sbox(s[127-32*r-8*((c+r)%4) -: 8]);
      for (int c = 0; c < 4; c++) begin
         m[0][c] = xtime(b[0][c]) ^ xtime(b[1][c]) ^ b[1][c] ^ b[2][c] ^ b[3][c];
         m[1][c] = b[0][c] ^ xtime(b[1][c]) ^ xtime(b[2][c]) ^ b[2][c] ^ b[3][c];
         m[2][c] = b[0][c] ^ b[1][c] ^ xtime(b[2][c]) ^ xtime(b[3][c]) ^ b[3][c];
         m[3][c] = xtime(b[0][c]) ^ b[0][c] ^ b[1][c] ^ b[2][c] ^ xtime(b[3][c]);
      end
      o = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-32*r-8*c -: 8] = last ? b[r][c] : m[r][c];
      return o ^ k;
   endfunction

   assign rk_next    = next_key(rk, rcon(round));
   assign state_next = enc_round(state, rk_next, round == LAST_ROUND);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm <= IDLE;
      else        fsm <= fsm_next;
   end

   // NOTE: the default is assigned before the case so no path leaves fsm_next unassigned (no latch).
   always_comb begin
      fsm_next = fsm;
      unique case (fsm)
         IDLE:    if (in_valid)             fsm_next = RUN;
         RUN:     if (round == LAST_ROUND)  fsm_next = DONE;
         DONE:    if (out_ready)            fsm_next = IDLE;
         default:                           fsm_next = IDLE;
      endcase
   end

   assign in_ready  = (fsm == IDLE);
   assign out_valid = (fsm == DONE);
   assign busy      = (fsm == RUN) || (fsm == DONE);

   // NOTE: the datapath registers are plain flops, so they take a reset value; an aborted block leaves no residue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= '0;
         rk       <= '0;
         round    <= '0;
         out_text <= '0;
      end else begin
         unique case (fsm)
            IDLE: begin
               if (in_valid) begin
                  state <= in_text ^ in_key;
                  rk    <= in_key;
                  round <= 4'd1;
               end
            end
            RUN: begin
               rk    <= rk_next;
               state <= state_next;
               if (round == LAST_ROUND) out_text <= state_next;
               else                     round    <= round + 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_enc_iter.sv
// Scoreboarded bench for aes128_enc_iter: known-answer vectors, latency, backpressure,
// back-to-back throughput, mid-run reset and input hold-change.
module tb_aes128_enc_iter;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_text;
   logic [127:0] in_key;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_text;
   logic         busy;

   int           n_cmp;
   int           n_bad;
   int           cyc;
   logic [127:0] exp_q [$];

   aes128_enc_iter #(.NUM_ROUNDS(10)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_text   (in_text),
      .in_key    (in_key),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_text  (out_text),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: bound expired", name);
   endtask

   // FIPS-197 vectors are column-major; the core uses row-major.
   function automatic logic [127:0] tr(input logic [127:0] f);
      logic [127:0] o;
      o = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[127-32*r-8*c -: 8] = f[127-32*c-8*r -: 8];
      return o;
   endfunction

   // Scoreboard monitor: every output handshake pops one expected ciphertext.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_output: got %h expected none", out_text);
         end else begin
            check("ciphertext", {4'h0, out_text}, {4'h0, exp_q.pop_front()});
         end
      end
   end

   // Offer a block and return once it is accepted; acc is the cycle count just after the accept edge.
   task automatic send(input logic [127:0] pt, input logic [127:0] key, input logic [127:0] ct,
                       output int acc);
      in_text  = pt;
      in_key   = key;
      in_valid = 1'b1;
      acc      = -1;
      for (int i = 0; i < 60 && acc < 0; i++) begin
         @(negedge clk);
         if (in_ready) begin
            exp_q.push_back(ct);
            @(posedge clk);
            #1;
            acc = cyc;
         end
      end
      if (acc < 0) fail_now("accept_timeout");
   endtask

   task automatic drain();
      bit done;
      done = 1'b0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0 && !busy) done = 1'b1;
      end
      check("drain_queue_empty", 132'(exp_q.size()), 132'd0);
   endtask

   localparam logic [127:0] C1_KEY  = 128'h0004080c_0105090d_02060a0e_03070b0f;
   localparam logic [127:0] C1_PT   = 128'h004488cc_115599dd_2266aaee_3377bbff;
   localparam logic [127:0] C1_CT   = 128'h696ad870_c47bcdb4_e004b7c5_d830805a;
   localparam logic [127:0] ZERO_CT = 128'h66ef88ca_e98a4c34_4b2cfa2b_d43b592e;
   localparam logic [127:0] FB_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FB_PT   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] FB_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] SP_PT   = 128'h6bc1bee22e409f96e93d7e117393172a;
   localparam logic [127:0] SP_CT   = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int acc0, acc1, acc2;
      bit seen;
      logic [127:0] b_key, b_pt, b_ct;

      n_cmp     = 0;
      n_bad     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_text   = '0;
      in_key    = '0;
      out_ready = 1'b1;
      b_key = tr(FB_KEY);
      b_pt  = tr(FB_PT);
      b_ct  = tr(FB_CT);

      // Reset values
      #22 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("reset_state", {1'b0, out_valid, in_ready, busy, out_text},
            {1'b0, 1'b0, 1'b1, 1'b0, 128'h0});

      // 1: FIPS C.1 and exact latency
      send(C1_PT, C1_KEY, C1_CT, acc0);
      in_valid = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("latency_T+%0d", k), {131'h0, out_valid}, {131'h0, k == 10});
      end
      drain();

      // 2: backpressure hold
      out_ready = 1'b0;
      send(b_pt, b_key, b_ct, acc0);
      in_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(posedge clk);
         #1;
         if (out_valid) seen = 1'b1;
      end
      if (!seen) fail_now("bp_wait_valid");
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check("bp_hold", {1'b0, out_valid, in_ready, busy, out_text},
               {1'b0, 1'b1, 1'b0, 1'b1, b_ct});
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release", {129'h0, out_valid, in_ready, busy}, {129'h0, 1'b0, 1'b1, 1'b0});
      check("bp_queue_empty", 132'(exp_q.size()), 132'd0);

      // 3: back-to-back, in_valid held high throughout
      send(C1_PT, C1_KEY, C1_CT, acc0);
      send(b_pt, b_key, b_ct, acc1);
      send(tr(SP_PT), b_key, tr(SP_CT), acc2);
      in_valid = 1'b0;
      check("b2b_spacing_1", 132'(acc1 - acc0), 132'd12);
      check("b2b_spacing_2", 132'(acc2 - acc1), 132'd12);
      drain();

      // 4: asynchronous reset at round 5
      send(C1_PT, C1_KEY, C1_CT, acc0);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      exp_q.delete();
      #2;
      check("abort_in_reset", {130'h0, out_valid, busy}, {130'h0, 1'b0, 1'b0});
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("abort_released", {1'b0, out_valid, in_ready, busy, out_text},
            {1'b0, 1'b0, 1'b1, 1'b0, 128'h0});
      send(b_pt, b_key, b_ct, acc0);
      in_valid = 1'b0;
      drain();

      // 5: inputs change right after accept
      send(tr(SP_PT), b_key, tr(SP_CT), acc0);
      in_valid = 1'b0;
      in_text  = ~tr(SP_PT);
      in_key   = 128'hdeadbeef_01234567_89abcdef_a5a5a5a5;
      drain();

      // 6: all-zero key and plaintext
      send(128'h0, 128'h0, ZERO_CT, acc0);
      in_valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
